// File: rtl/ps2_mouse_pkg.sv
// Shared types and protocol constants for the PS/2 mouse controller.
package ps2_mouse_pkg;

    typedef enum logic [3:0] {
        TX_RESET,
        WAIT_ACK_RST,
        WAIT_BAT,
        WAIT_ID,
        TX_ENABLE,
        WAIT_ACK_EN,
        PKT_B0,
        PKT_B1,
        PKT_B2,
        BACKOFF,
        FAILED
    } ps2_mouse_state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [7:0] ID_STD       = 8'h00;

    typedef struct packed {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } ps2_mouse_pkt_t;

endpackage

// File: rtl/ps2_timeout_timer.sv
// Down-counting timeout: load sets the count, expired is high once it reaches zero.
module ps2_timeout_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse sequencer: reset/enable handshake with retries, then 3-byte stream packet assembly.
module ps2_mouse_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT_CYC = 1_250_000,
    parameter int unsigned BAT_TIMEOUT_CYC = 25_000_000,
    parameter int unsigned PKT_GAP_CYC     = 50_000,
    parameter int unsigned BACKOFF_CYC     = 250_000,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_dout,
    input  logic       tx_idle,
    input  logic       tx_done_tick,
    output logic       wr_ps2,
    output logic [7:0] din,
    output logic       pkt_valid,
    output logic [2:0] pkt_btn,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy,
    output logic [1:0] pkt_ovf,
    output logic       init_done,
    output logic       failed,
    output logic [1:0] retry_cnt,
    output logic [7:0] sync_err_cnt
);

    ps2_mouse_state_t state, state_n;
    logic             tx_wait, tx_wait_n;  // TX sub-phase: 0 = request, 1 = waiting for tx_done_tick
    logic             fire_tx, fail, sync_inc, pkt_fire, cap_b0, cap_b1;
    logic [7:0]       cmd, b0_q, b1_q;
    logic [1:0]       retry_nxt;
    logic             tmr_load, expired;
    logic [31:0]      tmr_val;
    ps2_mouse_pkt_t   pkt_cur;

    ps2_timeout_timer #(.W(32)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_RESET;
            tx_wait <= 1'b0;
        end else begin
            state   <= state_n;
            tx_wait <= tx_wait_n;
        end
    end

    always_comb begin
        state_n   = state;
        tx_wait_n = tx_wait;
        fire_tx   = 1'b0;
        fail      = 1'b0;
        sync_inc  = 1'b0;
        pkt_fire  = 1'b0;
        cap_b0    = 1'b0;
        cap_b1    = 1'b0;
        cmd       = (state == TX_ENABLE) ? CMD_ENABLE : CMD_RESET;
        retry_nxt = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
        tmr_val   = RSP_TIMEOUT_CYC - 1;

        // A received byte always takes priority over a same-cycle expiry.
        case (state)
            TX_RESET, TX_ENABLE: begin
                if (!tx_wait) begin
                    if (tx_idle) begin
                        fire_tx   = 1'b1;
                        tx_wait_n = 1'b1;
                    end
                end else if (tx_done_tick) begin
                    state_n = (state == TX_RESET) ? WAIT_ACK_RST : WAIT_ACK_EN;
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            WAIT_ACK_RST, WAIT_ACK_EN: begin
                if (rx_done_tick) begin
                    if (rx_dout == RSP_ACK) begin
                        state_n = (state == WAIT_ACK_RST) ? WAIT_BAT : PKT_B0;
                    end else if (rx_dout == RSP_RESEND) begin
                        state_n = (state == WAIT_ACK_RST) ? TX_RESET : TX_ENABLE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            WAIT_BAT: begin
                if (rx_done_tick) begin
                    if (rx_dout == RSP_BAT_OK) begin
                        state_n = WAIT_ID;
                    end else if (rx_dout == RSP_BAT_FAIL) begin
                        fail = 1'b1;
                    end
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            WAIT_ID: begin
                if (rx_done_tick) begin
                    if (rx_dout == ID_STD) state_n = TX_ENABLE;
                    else                   fail    = 1'b1;
                end else if (expired) begin
                    fail = 1'b1;
                end
            end
            PKT_B0: begin
                if (rx_done_tick) begin
                    if (rx_dout[3]) begin
                        cap_b0  = 1'b1;
                        state_n = PKT_B1;
                    end else begin
                        sync_inc = 1'b1;
                    end
                end
            end
            PKT_B1: begin
                if (rx_done_tick) begin
                    cap_b1  = 1'b1;
                    state_n = PKT_B2;
                end else if (expired) begin
                    sync_inc = 1'b1;
                    state_n  = PKT_B0;
                end
            end
            PKT_B2: begin
                if (rx_done_tick) begin
                    pkt_fire = 1'b1;
                    state_n  = PKT_B0;
                end else if (expired) begin
                    sync_inc = 1'b1;
                    state_n  = PKT_B0;
                end
            end
            BACKOFF: begin
                if (expired) state_n = TX_RESET;
            end
            FAILED: begin
                state_n = FAILED;
            end
            default: begin
                state_n = TX_RESET;
            end
        endcase

        if (fail) begin
            state_n = (32'(retry_nxt) >= MAX_RETRIES) ? FAILED : BACKOFF;
        end
        if (state_n != state) begin
            tx_wait_n = 1'b0;
        end

        tmr_load = (state_n != state) || fire_tx;
        case (state_n)
            WAIT_BAT:       tmr_val = BAT_TIMEOUT_CYC - 1;
            PKT_B1, PKT_B2: tmr_val = PKT_GAP_CYC - 1;
            BACKOFF:        tmr_val = BACKOFF_CYC - 1;
            default:        tmr_val = RSP_TIMEOUT_CYC - 1;
        endcase
    end

    assign pkt_cur = '{b0: b0_q, b1: b1_q, b2: rx_dout};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ps2       <= 1'b0;
            din          <= 8'h00;
            pkt_valid    <= 1'b0;
            pkt_btn      <= 3'd0;
            pkt_dx       <= 9'd0;
            pkt_dy       <= 9'd0;
            pkt_ovf      <= 2'd0;
            retry_cnt    <= 2'd0;
            sync_err_cnt <= 8'd0;
            b0_q         <= 8'h00;
            b1_q         <= 8'h00;
        end else begin
            wr_ps2    <= fire_tx;
            pkt_valid <= pkt_fire;
            if (fire_tx) din <= cmd;
            if (fail) retry_cnt <= retry_nxt;
            if (sync_inc && (sync_err_cnt != 8'hFF)) sync_err_cnt <= sync_err_cnt + 8'd1;
            if (cap_b0) b0_q <= rx_dout;
            if (cap_b1) b1_q <= rx_dout;
            if (pkt_fire) begin
                pkt_btn <= pkt_cur.b0[2:0];
                pkt_dx  <= {pkt_cur.b0[4], pkt_cur.b1};
                pkt_dy  <= {pkt_cur.b0[5], pkt_cur.b2};
                pkt_ovf <= pkt_cur.b0[7:6];
            end
        end
    end

    assign init_done = (state == PKT_B0) || (state == PKT_B1) || (state == PKT_B2);
    assign failed    = (state == FAILED);

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Self-checking bench for ps2_mouse_ctrl: init handshakes, retries, packet stream vs a byte-level model.
module tb_ps2_mouse_ctrl;

    localparam int RSP  = 40;
    localparam int BAT  = 80;
    localparam int GAP  = 30;
    localparam int BOFF = 50;
    localparam int MAXR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       tx_idle = 1'b1;
    logic       tx_done_tick = 1'b0;
    logic       wr_ps2;
    logic [7:0] din;
    logic       pkt_valid;
    logic [2:0] pkt_btn;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;
    logic [1:0] pkt_ovf;
    logic       init_done;
    logic       failed;
    logic [1:0] retry_cnt;
    logic [7:0] sync_err_cnt;

    ps2_mouse_ctrl #(
        .RSP_TIMEOUT_CYC (RSP),
        .BAT_TIMEOUT_CYC (BAT),
        .PKT_GAP_CYC     (GAP),
        .BACKOFF_CYC     (BOFF),
        .MAX_RETRIES     (MAXR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .pkt_valid    (pkt_valid),
        .pkt_btn      (pkt_btn),
        .pkt_dx       (pkt_dx),
        .pkt_dy       (pkt_dy),
        .pkt_ovf      (pkt_ovf),
        .init_done    (init_done),
        .failed       (failed),
        .retry_cnt    (retry_cnt),
        .sync_err_cnt (sync_err_cnt)
    );

    // Clock / reset
    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int tx_done_n = 0;
    int wr_cyc_q[$];

    // Scoreboard state: expected commands, expected packets {btn, dx, dy, ovf}
    logic [7:0]  exp_cmd_q[$];
    logic [22:0] exp_pkt_q[$];
    logic [22:0] last_pkt = '0;
    int          m_pos = 0;
    logic [7:0]  m_b0 = 8'h00;
    logic [7:0]  m_b1 = 8'h00;
    int          exp_sync = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_wait(input string name, input int budget);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not seen within %0d cycles", name, budget);
    endtask

    function automatic logic [22:0] decode(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx;
        int dy;
        logic [8:0] dx9;
        logic [8:0] dy9;
        dx  = b0[4] ? int'(b1) - 256 : int'(b1);
        dy  = b0[5] ? int'(b2) - 256 : int'(b2);
        dx9 = dx[8:0];
        dy9 = dy[8:0];
        return {b0[2:0], dx9, dy9, b0[7:6]};
    endfunction

    // Driver tasks (called at posedge+1)
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_dout      = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic sync_bump();
        if (exp_sync < 255) exp_sync++;
    endtask

    task automatic assert_rst_now();
        rst = 1'b1;
        exp_cmd_q.delete();
        exp_pkt_q.delete();
        last_pkt = '0;
        m_pos    = 0;
        exp_sync = 0;
    endtask

    task automatic apply_reset();
        assert_rst_now();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_ps2"}, 32'(wr_ps2), 0);
        chk({tag, "_din"}, 32'(din), 0);
        chk({tag, "_pkt_valid"}, 32'(pkt_valid), 0);
        chk({tag, "_pkt_fields"}, 32'({pkt_btn, pkt_dx, pkt_dy, pkt_ovf}), 0);
        chk({tag, "_init_done"}, 32'(init_done), 0);
        chk({tag, "_failed"}, 32'(failed), 0);
        chk({tag, "_retry_cnt"}, 32'(retry_cnt), 0);
        chk({tag, "_sync_err_cnt"}, 32'(sync_err_cnt), 0);
    endtask

    task automatic wait_wr(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (n_wr >= target) return;
            @(posedge clk);
            #1;
        end
        if (n_wr < target) fail_wait(name, budget);
    endtask

    task automatic wait_txd(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (tx_done_n >= target) return;
            @(posedge clk);
            #1;
        end
        if (tx_done_n < target) fail_wait(name, budget);
    endtask

    // Stream byte with a behavioural packet model; idle_n idle cycles precede the tick.
    task automatic stream_byte(input logic [7:0] b, input int idle_n);
        int d;
        bit done;
        idle(idle_n);
        d    = idle_n + 1;
        done = 1'b0;
        if (m_pos != 0 && d > GAP) begin
            sync_bump();
            m_pos = 0;
        end
        if (m_pos == 0) begin
            if (b[3]) begin
                m_b0  = b;
                m_pos = 1;
            end else begin
                sync_bump();
            end
        end else if (m_pos == 1) begin
            m_b1  = b;
            m_pos = 2;
        end else begin
            exp_pkt_q.push_back(decode(m_b0, m_b1, b));
            m_pos = 0;
            done  = 1'b1;
        end
        send_rx(b);
        if (done) chk("pkt_latency", 32'(pkt_valid), 1);
    endtask

    task automatic flush_gap();
        idle(GAP + 10);
        if (m_pos != 0) begin
            sync_bump();
            m_pos = 0;
        end
    endtask

    task automatic do_init(input bit resend);
        int base;
        int txb;
        base = n_wr;
        txb  = tx_done_n;
        exp_cmd_q.push_back(8'hFF);
        exp_cmd_q.push_back(8'hF4);
        if (resend) exp_cmd_q.push_back(8'hF4);
        wait_txd(txb + 1, 200, "init_tx_reset_done");
        idle(2);
        send_rx(8'hFA);
        idle(3);
        send_rx(8'h55);
        idle(3);
        send_rx(8'hAA);
        idle(2);
        send_rx(8'h00);
        wait_txd(txb + 2, 200, "init_tx_enable_done");
        idle(2);
        if (resend) begin
            send_rx(8'hFE);
            wait_txd(txb + 3, 200, "init_tx_enable_resent");
            idle(2);
        end
        send_rx(8'hFA);
        chk("init_done", 32'(init_done), 1);
        chk("init_retry_cnt", 32'(retry_cnt), 0);
        chk("init_failed", 32'(failed), 0);
        chk("init_wr_count", 32'(n_wr - base), resend ? 32'd3 : 32'd2);
        chk("init_cmds_left", 32'(exp_cmd_q.size()), 0);
    endtask

    // Device-side transmitter responder
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            if (wr_ps2) begin
                lat = $urandom_range(2, 6);
                @(posedge clk);
                #1 tx_idle = 1'b0;
                repeat (lat) @(posedge clk);
                #1 tx_done_tick = 1'b1;
                @(posedge clk);
                #1 tx_done_tick = 1'b0;
                tx_idle = 1'b1;
                tx_done_n++;
            end
        end
    end

    // Compare process
    initial begin
        logic wr_prev;
        logic pv_prev;
        wr_prev = 1'b0;
        pv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_ps2) begin
                chk("wr_pulse_width", 32'(wr_prev), 0);
                if (exp_cmd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got transmit of 0x%0h at cycle %0d, expected none", din, cyc);
                end else begin
                    chk("din", 32'(din), 32'(exp_cmd_q.pop_front()));
                end
                n_wr++;
                wr_cyc_q.push_back(cyc);
            end
            wr_prev = wr_ps2;
            if (pkt_valid) begin
                chk("pkt_valid_width", 32'(pv_prev), 0);
                if (exp_pkt_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pkt_unexpected: got packet 0x%0h, expected none",
                             {pkt_btn, pkt_dx, pkt_dy, pkt_ovf});
                end else begin
                    last_pkt = exp_pkt_q.pop_front();
                    chk("pkt_fields", 32'({pkt_btn, pkt_dx, pkt_dy, pkt_ovf}), 32'(last_pkt));
                end
            end else begin
                chk("pkt_hold", 32'({pkt_btn, pkt_dx, pkt_dy, pkt_ovf}), 32'(last_pkt));
            end
            pv_prev = pkt_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    // Main sequence
    initial begin
        int base;
        int g;
        int found;
        logic [7:0] b;

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        apply_reset();

        // Normal init, then directed packets
        do_init(1'b0);
        chk("init_sync_err", 32'(sync_err_cnt), 0);
        stream_byte(8'h18, 2);
        stream_byte(8'hFB, 2);
        stream_byte(8'h05, 2);
        chk("lit_dx_neg5", 32'(pkt_dx), 32'h1FB);
        chk("lit_dy_pos5", 32'(pkt_dy), 32'h005);
        chk("lit_btn0", 32'(pkt_btn), 0);
        chk("lit_ovf0", 32'(pkt_ovf), 0);
        idle(1);
        chk("lit_strobe_drop", 32'(pkt_valid), 0);
        stream_byte(8'hEF, 3);
        stream_byte(8'h7F, 3);
        stream_byte(8'h01, 3);
        chk("lit_dx_pos127", 32'(pkt_dx), 32'h07F);
        chk("lit_dy_neg255", 32'(pkt_dy), 32'h101);
        chk("lit_btn7", 32'(pkt_btn), 7);
        chk("lit_ovf3", 32'(pkt_ovf), 3);

        // Resync: bad header, then a partial packet that times out
        stream_byte(8'h00, 2);
        chk("resync_bad_header", 32'(sync_err_cnt), 1);
        chk("resync_no_pkt", 32'(pkt_valid), 0);
        stream_byte(8'h09, 2);
        flush_gap();
        chk("resync_gap", 32'(sync_err_cnt), 2);
        chk("resync_init_done", 32'(init_done), 1);

        // Randomized stream
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 9) == 0) begin
                b = 8'($urandom_range(0, 255)) & 8'hF7;
                stream_byte(b, $urandom_range(1, 4));
            end
            for (int k = 0; k < 3; k++) begin
                b = 8'($urandom_range(0, 255));
                if (k == 0) b = b | 8'h08;
                if ($urandom_range(0, 7) == 0) stream_byte(b, $urandom_range(GAP + 3, GAP + 15));
                else                           stream_byte(b, $urandom_range(1, GAP - 4));
            end
        end
        flush_gap();
        chk("rand_sync_err", 32'(sync_err_cnt), 32'(exp_sync));
        chk("rand_pkts_pending", 32'(exp_pkt_q.size()), 0);
        chk("rand_init_done", 32'(init_done), 1);

        // Saturation of the discard counter
        for (int i = 0; i < 260; i++) begin
            b = 8'($urandom_range(0, 255)) & 8'hF7;
            stream_byte(b, 1);
        end
        chk("sync_err_saturate", 32'(sync_err_cnt), 255);
        chk("sync_err_model", 32'(sync_err_cnt), 32'(exp_sync));

        // Reset mid-packet
        stream_byte(8'h08, 2);
        stream_byte(8'h11, 2);
        #2;
        assert_rst_now();
        #1;
        chk_zero("midpkt_rst");
        apply_reset();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_ps2) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("post_rst_wr_seen", 32'(found), 1);
        chk("post_rst_din", 32'(din), 32'hFF);
        #1;
        assert_rst_now();
        #1;
        chk("wr_drop_on_rst", 32'(wr_ps2), 0);
        apply_reset();

        // Resend of the enable command
        do_init(1'b1);

        // Silent device
        apply_reset();
        base = n_wr;
        exp_cmd_q.push_back(8'hFF);
        exp_cmd_q.push_back(8'hFF);
        exp_cmd_q.push_back(8'hFF);
        wait_wr(base + 1, 50, "silent_wr1");
        wait_wr(base + 2, 600, "silent_wr2");
        chk("silent_retry1", 32'(retry_cnt), 1);
        if (wr_cyc_q.size() >= 2) begin
            g = wr_cyc_q[wr_cyc_q.size() - 1] - wr_cyc_q[wr_cyc_q.size() - 2];
            chk("silent_gap1_in_window", 32'((g >= RSP + BOFF) && (g <= RSP + BOFF + 15)), 1);
        end
        wait_wr(base + 3, 600, "silent_wr3");
        chk("silent_retry2", 32'(retry_cnt), 2);
        if (wr_cyc_q.size() >= 2) begin
            g = wr_cyc_q[wr_cyc_q.size() - 1] - wr_cyc_q[wr_cyc_q.size() - 2];
            chk("silent_gap2_in_window", 32'((g >= RSP + BOFF) && (g <= RSP + BOFF + 15)), 1);
        end
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if (failed) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (found == 0) fail_wait("silent_failed", 400);
        chk("silent_failed", 32'(failed), 1);
        chk("silent_retry3", 32'(retry_cnt), 3);
        chk("silent_init_done", 32'(init_done), 0);
        idle(300);
        chk("silent_no_more_wr", 32'(n_wr - base), 3);
        chk("silent_failed_hold", 32'(failed), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
